alu_result_uart_tx: RTL and testbench

//   Serialises one NB_DATA-bit word (the ALU result) onto an asynchronous UART line: start, data LSB-first, stop.

---
 rtl/alu_result_uart_tx_if.sv | 19 +
 rtl/alu_result_uart_tx.sv | 131 +++++++++++++
 tb/tb_alu_result_uart_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_uart_tx_if.sv
// Handshake and serial-line bundle between the ALU result source and the UART transmitter.
//   i_tx_valid  source -> tx   word on i_tx_data is ready to send
//   i_tx_data   source -> tx   word to transmit (NB_DATA bits)
//   o_tx_ready  tx -> source   transmitter idle, accepts a word this cycle
//   o_tx        tx -> pin      serial line, idles high
//   o_tx_done   tx -> source   1-cycle pulse after the stop bit completes
// master = the side producing words (ALU / bench), slave = the transmitter.
interface alu_result_uart_tx_if #(
  parameter int NB_DATA = 8
) ();
  logic               i_tx_valid;
  logic [NB_DATA-1:0] i_tx_data;
  logic               o_tx_ready;
  logic               o_tx;
  logic               o_tx_done;

  modport master (output i_tx_valid, i_tx_data, input o_tx_ready, o_tx, o_tx_done);
  modport slave  (input i_tx_valid, i_tx_data, output o_tx_ready, o_tx, o_tx_done);
endinterface

// File: rtl/alu_result_uart_tx.sv
// UART transmitter for the ALU result: start bit, NB_DATA data bits LSB first, stop.
// Includes a 16x-oversample baud tick generator and a valid/ready accept.
//   i_clk    clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      slave side of alu_result_uart_tx_if (valid/data in, ready/tx/done out)
// All outputs are registered; they are computed from the next-state values.
// DVSR = CLK_FREQ/(BAUD_RATE*16) must be at least 2.
module alu_result_uart_tx #(
  parameter int NB_DATA   = 8,
  parameter int SB_TICK   = 16,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input logic i_clk,
  input logic i_reset,
  alu_result_uart_tx_if.slave bus
);
  localparam int DVSR = CLK_FREQ / (BAUD_RATE * 16);
  localparam int CW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [CW-1:0] C_LAST      = CW'(DVSR - 1);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      s_q, s_d;
  logic [NW-1:0]      n_q, n_d;
  logic [NB_DATA-1:0] sh_q, sh_d;
  logic               tx_q, tx_d;
  logic               ready_q;
  logic               done_q, done_d;
  logic               tick;

  assign tick           = (cnt_q == C_LAST);
  assign bus.o_tx       = tx_q;
  assign bus.o_tx_ready = ready_q;
  assign bus.o_tx_done  = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // ready_q is high exactly in IDLE; clearing the baud counter here
        // gives every frame the same tick phase.
        if (ready_q && bus.i_tx_valid) begin
          state_d = START;
          cnt_d   = '0;
          s_d     = '0;
          n_d     = '0;
          sh_d    = bus.i_tx_data;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d  = '0;
            sh_d = sh_q >> 1;
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            s_d     = '0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // line level for the coming cycle
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      ready_q <= (state_d == IDLE);
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: two instances (1 and 2 stop bits) at DVSR=10.
// A frame-position model predicts o_tx/o_tx_ready/o_tx_done every cycle, and a
// mid-bit decoder compares received bytes against the accepted words.
module tb_alu_result_uart_tx;
  localparam int BITP = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_result_uart_tx_if #(.NB_DATA(8)) bus0 ();
  alu_result_uart_tx_if #(.NB_DATA(8)) bus1 ();

  alu_result_uart_tx #(.NB_DATA(8), .SB_TICK(16), .CLK_FREQ(1_600_000), .BAUD_RATE(10_000))
    dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0));
  alu_result_uart_tx #(.NB_DATA(8), .SB_TICK(32), .CLK_FREQ(1_600_000), .BAUD_RATE(10_000))
    dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         flen [2] = '{1600, 1760};
  bit         m_busy [2];
  int         m_pos [2];
  logic [7:0] m_word [2];
  bit         m_done [2];
  int         m_acc [2];
  int         acc_cyc [2];
  int         done_cyc [2];
  logic [7:0] expq [2][$];
  bit         dec_act [2];
  int         dec_cnt [2];
  logic [7:0] dec_sh [2];
  logic [7:0] dec_last [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic lvl(input logic [7:0] w, input int p);
    int b;
    b = p / BITP;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    return 1'b1;
  endfunction

  // advance the model by one edge, then compare and decode
  task automatic step(input int d, input logic r, input logic v, input logic [7:0] dat,
                      input logic tx, input logic rdy, input logic dn);
    logic ex;
    int k;
    if (r) begin
      m_busy[d] = 0; m_done[d] = 0; dec_act[d] = 0;
      expq[d].delete();
    end else if (!m_busy[d]) begin
      m_done[d] = 0;
      if (v) begin
        m_busy[d] = 1; m_pos[d] = 0; m_word[d] = dat;
        m_acc[d]++; acc_cyc[d] = cyc;
        expq[d].push_back(dat);
      end
    end else begin
      m_pos[d]++;
      if (m_pos[d] == flen[d]) begin m_busy[d] = 0; m_done[d] = 1; end
    end
    ex = m_busy[d] ? lvl(m_word[d], m_pos[d]) : 1'b1;
    check($sformatf("tx%0d", d), {31'b0, tx}, {31'b0, ex});
    check($sformatf("ready%0d", d), {31'b0, rdy}, {31'b0, !m_busy[d]});
    check($sformatf("done%0d", d), {31'b0, dn}, {31'b0, m_done[d]});
    if (dn === 1'b1) done_cyc[d] = cyc;
    if (!r) begin
      if (!dec_act[d] && tx === 1'b0) begin dec_act[d] = 1; dec_cnt[d] = 0; end
      else if (dec_act[d]) dec_cnt[d]++;
      if (dec_act[d]) begin
        if (dec_cnt[d] == 80) check($sformatf("dec_start%0d", d), {31'b0, tx}, 32'd0);
        else if (dec_cnt[d] > 80 && (dec_cnt[d] - 80) % BITP == 0) begin
          k = (dec_cnt[d] - 80) / BITP - 1;
          if (k < 8) dec_sh[d][k] = tx;
          else begin
            check($sformatf("dec_stop%0d", d), {31'b0, tx}, 32'd1);
            if (expq[d].size() == 0) check($sformatf("dec_unexpected%0d", d), {24'b0, dec_sh[d]}, 32'hFFFF_FFFF);
            else check($sformatf("dec_byte%0d", d), {24'b0, dec_sh[d]}, {24'b0, expq[d].pop_front()});
            dec_last[d] = dec_sh[d];
            dec_act[d]  = 0;
          end
        end
      end
    end
  endtask

  logic       s_r, s_v0, s_v1;
  logic [7:0] s_d0, s_d1;
  always begin
    @(posedge clk);
    s_r = rst; s_v0 = bus0.i_tx_valid; s_d0 = bus0.i_tx_data;
    s_v1 = bus1.i_tx_valid; s_d1 = bus1.i_tx_data;
    #1;
    cyc++;
    step(0, s_r, s_v0, s_d0, bus0.o_tx, bus0.o_tx_ready, bus0.o_tx_done);
    step(1, s_r, s_v1, s_d1, bus1.o_tx, bus1.o_tx_ready, bus1.o_tx_done);
  end

  task automatic drv(input int d, input logic v, input logic [7:0] dat);
    if (d == 0) begin bus0.i_tx_valid = v; bus0.i_tx_data = dat; end
    else        begin bus1.i_tx_valid = v; bus1.i_tx_data = dat; end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (m_busy[d] && n < budget) begin @(negedge clk); n++; end
    if (m_busy[d]) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_acc(input int d, input int budget);
    int a0 = m_acc[d];
    int n  = 0;
    while (m_acc[d] == a0 && n < budget) begin @(negedge clk); n++; end
    if (m_acc[d] == a0) check("accept_timeout", 32'd1, 32'd0);
  endtask

  // present a word for one cycle; optionally hammer valid with junk until idle
  task automatic send(input int d, input logic [7:0] dat, input bit junk);
    drv(d, 1'b1, dat);
    wait_acc(d, 4);
    drv(d, 1'b0, 8'h00);
    if (junk) begin
      while (m_busy[d]) begin
        drv(d, 1'b1, 8'(($urandom % 2) ? 8'hFF : 8'($urandom)));
        @(negedge clk);
      end
      drv(d, 1'b0, 8'h00);
    end
  endtask

  int first_acc;
  initial begin
    drv(0, 1'b0, 8'h00);
    drv(1, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", {31'b0, bus0.o_tx}, 32'd1);
    check("rst_ready", {31'b0, bus0.o_tx_ready}, 32'd1);
    check("rst_done", {31'b0, bus0.o_tx_done}, 32'd0);
    repeat (500) @(negedge clk);

    send(0, 8'hA5, 1'b0);
    wait_idle(0, 2000);
    check("len_a5", done_cyc[0] - acc_cyc[0], 32'd1600);
    check("dec_a5", {24'b0, dec_last[0]}, 32'h0000_00A5);

    send(0, 8'h3C, 1'b1);
    wait_idle(0, 2000);
    check("len_3c", done_cyc[0] - acc_cyc[0], 32'd1600);
    check("dec_3c", {24'b0, dec_last[0]}, 32'h0000_003C);

    drv(0, 1'b1, 8'h00);
    wait_acc(0, 4);
    first_acc = acc_cyc[0];
    drv(0, 1'b1, 8'hFF);
    wait_acc(0, 2000);
    drv(0, 1'b0, 8'h00);
    check("b2b_gap", acc_cyc[0] - first_acc, 32'd1601);
    wait_idle(0, 2000);
    check("dec_ff", {24'b0, dec_last[0]}, 32'h0000_00FF);

    send(0, 8'h81, 1'b0);
    while (m_pos[0] < 880) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", {31'b0, bus0.o_tx}, 32'd1);
    check("abort_ready", {31'b0, bus0.o_tx_ready}, 32'd1);
    repeat (200) @(negedge clk);
    send(0, 8'h55, 1'b0);
    wait_idle(0, 2000);
    check("dec_55", {24'b0, dec_last[0]}, 32'h0000_0055);

    send(1, 8'h0F, 1'b0);
    wait_idle(1, 2500);
    check("len_2stop", done_cyc[1] - acc_cyc[1], 32'd1760);
    check("dec_0f", {24'b0, dec_last[1]}, 32'h0000_000F);

    for (int i = 0; i < 6; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      send(d, 8'($urandom), bit'($urandom_range(0, 1)));
      wait_idle(d, 2500);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("q_empty0", expq[0].size(), 32'd0);
    check("q_empty1", expq[1].size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
